// File: rtl/dram_frontend_scheduler.sv
// Single-outstanding, in-order scheduler between the core interconnect and the DRAM backend.
// Packs narrow write beats into one backend word and splits read returns into tagged beats.
module dram_frontend_scheduler #(
    parameter int FRONTEND_WORD_SIZE = 128,
    parameter int BACKEND_WORD_SIZE  = 512,
    parameter int ROW_W              = 16,
    parameter int COL_W              = 10,
    parameter int BANK_W             = 3,
    parameter int ID_W               = 4,
    parameter int CORE_W             = 2,
    localparam int CMD_W             = 1 + ROW_W + COL_W + BANK_W + ID_W + CORE_W
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    output logic                          o_scheduler_ready,
    input  logic                          i_interconnection_request_valid,
    input  logic [CMD_W-1:0]              i_interconnection_request,
    input  logic [FRONTEND_WORD_SIZE-1:0] i_interconnection_write_data,
    input  logic                          i_interconnection_write_data_last,
    input  logic                          i_backend_controller_ready,
    output logic                          o_frontend_command_valid,
    output logic [CMD_W-1:0]              o_frontend_command,
    output logic [BACKEND_WORD_SIZE-1:0]  o_frontend_write_data,
    output logic                          o_stall_backend_controller,
    output logic                          o_frontend_receive_ready,
    input  logic                          i_returned_data_valid,
    input  logic [BACKEND_WORD_SIZE-1:0]  i_returned_data,
    input  logic                          i_interconnection_ready,
    output logic                          o_scheduler_request_valid,
    output logic [FRONTEND_WORD_SIZE-1:0] o_scheduler_read_data,
    output logic                          o_scheduler_read_data_last,
    output logic [ID_W-1:0]               o_scheduler_request_id,
    output logic [CORE_W-1:0]             o_scheduler_core_num
);

    localparam int unsigned BEATS = BACKEND_WORD_SIZE / FRONTEND_WORD_SIZE;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, WDATA, ISSUE, WAIT_R, SEND_R} state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               beat_q, beat_d;
    logic [CMD_W-1:0]               cmd_q, cmd_d;
    logic [BACKEND_WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic [BACKEND_WORD_SIZE-1:0]   rdata_q, rdata_d;
    logic                           ready_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            cmd_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            // Ready is registered from the next state so it stays low through reset
            ready_q <= (state_d == IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cmd_d   = cmd_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (i_interconnection_request_valid && ready_q) begin
                    cmd_d   = i_interconnection_request;
                    beat_d  = '0;
                    wdata_d = '0;
                    if (i_interconnection_request[CMD_W-1]) begin
                        wdata_d[FRONTEND_WORD_SIZE-1:0] = i_interconnection_write_data;
                        if (i_interconnection_write_data_last || BEATS == 1) begin
                            state_d = ISSUE;
                        end else begin
                            state_d = WDATA;
                            beat_d  = CNT_W'(1);
                        end
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            WDATA: begin
                for (int unsigned k = 0; k < BEATS; k++) begin
                    if (beat_q == CNT_W'(k)) begin
                        wdata_d[k*FRONTEND_WORD_SIZE +: FRONTEND_WORD_SIZE] = i_interconnection_write_data;
                    end
                end
                if (i_interconnection_write_data_last || beat_q == LAST_BEAT) begin
                    state_d = ISSUE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ISSUE: begin
                if (i_backend_controller_ready) begin
                    state_d = cmd_q[CMD_W-1] ? IDLE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (i_returned_data_valid) begin
                    rdata_d = i_returned_data;
                    beat_d  = '0;
                    state_d = SEND_R;
                end
            end
            SEND_R: begin
                if (i_interconnection_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_scheduler_ready          = ready_q;
        o_frontend_command_valid   = (state_q == ISSUE);
        o_frontend_command         = cmd_q;
        o_frontend_write_data      = wdata_q;
        o_stall_backend_controller = (state_q == SEND_R);
        o_frontend_receive_ready   = (state_q == WAIT_R);
        o_scheduler_request_valid  = (state_q == SEND_R);
        o_scheduler_read_data_last = (state_q == SEND_R) && (beat_q == LAST_BEAT);
        o_scheduler_request_id     = cmd_q[CORE_W +: ID_W];
        o_scheduler_core_num       = cmd_q[CORE_W-1:0];
        o_scheduler_read_data      = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (state_q == SEND_R && beat_q == CNT_W'(k)) begin
                o_scheduler_read_data = rdata_q[k*FRONTEND_WORD_SIZE +: FRONTEND_WORD_SIZE];
            end
        end
    end

endmodule

// File: tb/tb_dram_frontend_scheduler.sv
// Directed + randomized bench for dram_frontend_scheduler; expected beats and words come
// from a transaction-level model (beat lists and word slices) held in the bench.
module tb_dram_frontend_scheduler;

    localparam int F      = 128;
    localparam int B      = 512;
    localparam int BEATS  = B / F;
    localparam int ROW_W  = 16;
    localparam int COL_W  = 10;
    localparam int BANK_W = 3;
    localparam int ID_W   = 4;
    localparam int CORE_W = 2;
    localparam int CMD_W  = 1 + ROW_W + COL_W + BANK_W + ID_W + CORE_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sched_rdy;
    logic             i_valid;
    logic [CMD_W-1:0] i_req;
    logic [F-1:0]     i_wd;
    logic             i_last;
    logic             i_be_rdy;
    logic             cmd_valid;
    logic [CMD_W-1:0] cmd_out;
    logic [B-1:0]     wdata_out;
    logic             stall;
    logic             recv_rdy;
    logic             i_rvalid;
    logic [B-1:0]     i_rdata;
    logic             i_ic_rdy;
    logic             req_valid;
    logic [F-1:0]     rd_data;
    logic             rd_last;
    logic [ID_W-1:0]  req_id;
    logic [CORE_W-1:0] core_num;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dram_frontend_scheduler #(
        .FRONTEND_WORD_SIZE(F), .BACKEND_WORD_SIZE(B), .ROW_W(ROW_W), .COL_W(COL_W),
        .BANK_W(BANK_W), .ID_W(ID_W), .CORE_W(CORE_W)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_scheduler_ready(sched_rdy),
        .i_interconnection_request_valid(i_valid), .i_interconnection_request(i_req),
        .i_interconnection_write_data(i_wd), .i_interconnection_write_data_last(i_last),
        .i_backend_controller_ready(i_be_rdy), .o_frontend_command_valid(cmd_valid),
        .o_frontend_command(cmd_out), .o_frontend_write_data(wdata_out),
        .o_stall_backend_controller(stall), .o_frontend_receive_ready(recv_rdy),
        .i_returned_data_valid(i_rvalid), .i_returned_data(i_rdata),
        .i_interconnection_ready(i_ic_rdy), .o_scheduler_request_valid(req_valid),
        .o_scheduler_read_data(rd_data), .o_scheduler_read_data_last(rd_last),
        .o_scheduler_request_id(req_id), .o_scheduler_core_num(core_num)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [F-1:0] rnd_beat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [CMD_W-1:0] mk_cmd(input logic op, input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col, input logic [BANK_W-1:0] bank,
                                                 input logic [ID_W-1:0] id, input logic [CORE_W-1:0] core);
        return {op, row, col, bank, id, core};
    endfunction

    function automatic logic [CMD_W-1:0] rnd_cmd(input logic op);
        return mk_cmd(op, ROW_W'($urandom), COL_W'($urandom), BANK_W'($urandom),
                      ID_W'($urandom), CORE_W'($urandom));
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"},   512'(sched_rdy), '0);
        chk({tag, "_cval"},  512'(cmd_valid), '0);
        chk({tag, "_cmd"},   512'(cmd_out),   '0);
        chk({tag, "_wdat"},  wdata_out,       '0);
        chk({tag, "_stall"}, 512'(stall),     '0);
        chk({tag, "_rrdy"},  512'(recv_rdy),  '0);
        chk({tag, "_rval"},  512'(req_valid), '0);
        chk({tag, "_rdat"},  512'(rd_data),   '0);
        chk({tag, "_last"},  512'(rd_last),   '0);
        chk({tag, "_id"},    512'(req_id),    '0);
        chk({tag, "_core"},  512'(core_num),  '0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdy"},   512'(sched_rdy), 512'(1));
        chk({tag, "_cval"},  512'(cmd_valid), '0);
        chk({tag, "_rval"},  512'(req_valid), '0);
        chk({tag, "_stall"}, 512'(stall),     '0);
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 20; c++) begin
            if (sched_rdy) break;
            tick();
        end
        chk("accept_rdy", 512'(sched_rdy), 512'(1));
    endtask

    // nlast >= BEATS means last is never raised within the word; nib==0 gives beats 1,2,3,...
    task automatic do_write(input logic [CMD_W-1:0] cmd, input int nlast, input int bp, input logic [3:0] nib);
        logic [F-1:0] beats[BEATS];
        logic [F-1:0] r;
        logic [B-1:0] exp_w;
        int nb;
        nb = (nlast >= BEATS) ? BEATS : nlast + 1;
        exp_w = '0;
        for (int k = 0; k < BEATS; k++) begin
            r = rnd_beat();
            beats[k] = (nib == 4'd0) ? F'(k + 1) : {nib + 4'(k), r[F-5:0]};
        end
        for (int k = 0; k < nb; k++) exp_w[k*F +: F] = beats[k];
        wait_ready();
        i_valid = 1'b1; i_req = cmd; i_wd = beats[0]; i_last = (nlast == 0);
        tick();
        i_valid = 1'b0; i_req = rnd_cmd(1'b0);
        for (int k = 1; k < nb; k++) begin
            chk("wbeat_busy", 512'(sched_rdy), '0);
            i_wd = beats[k]; i_last = (k == nlast);
            tick();
        end
        i_wd = rnd_beat(); i_last = 1'b1;
        for (int c = 0; c < bp; c++) begin
            chk("w_hold_cval", 512'(cmd_valid), 512'(1));
            chk("w_hold_cmd",  512'(cmd_out),   512'(cmd));
            chk("w_hold_wdat", wdata_out,       exp_w);
            tick();
        end
        i_be_rdy = 1'b1;
        chk("w_iss_cval", 512'(cmd_valid), 512'(1));
        chk("w_iss_cmd",  512'(cmd_out),   512'(cmd));
        chk("w_iss_wdat", wdata_out,       exp_w);
        tick();
        i_be_rdy = 1'b0; i_last = 1'b0;
        chk_idle("w_done");
    endtask

    // mode: 0 always ready, 1 toggling 1,0,1,0, other random. stop_at < BEATS leaves it mid-SEND_R.
    task automatic do_read(input logic [CMD_W-1:0] cmd, input logic [B-1:0] word, input int lat,
                           input int mode, input int stop_at, input bit hold,
                           input logic [CMD_W-1:0] hcmd, input logic [F-1:0] hbeat);
        logic [F-1:0] q[$];
        logic ir;
        int cyc;
        for (int k = 0; k < BEATS; k++) q.push_back(word[k*F +: F]);
        wait_ready();
        i_valid = 1'b1; i_req = cmd; i_wd = rnd_beat(); i_last = 1'($urandom);
        tick();
        i_valid = 1'b0; i_last = 1'b0;
        chk("r_iss_cval", 512'(cmd_valid), 512'(1));
        chk("r_iss_cmd",  512'(cmd_out),   512'(cmd));
        chk("r_iss_wdat", wdata_out,       '0);
        i_be_rdy = 1'b1;
        tick();
        i_be_rdy = 1'b0;
        if (hold) begin
            i_valid = 1'b1; i_req = hcmd; i_wd = hbeat; i_last = 1'b1;
        end
        for (int c = 0; c < lat; c++) begin
            chk("r_wait_rrdy", 512'(recv_rdy),  512'(1));
            chk("r_wait_rdy",  512'(sched_rdy), '0);
            tick();
        end
        chk("r_recv_rdy", 512'(recv_rdy), 512'(1));
        i_rvalid = 1'b1; i_rdata = word;
        tick();
        i_rdata = ~word;
        cyc = 0;
        while (q.size() != 0 && cyc < 64) begin
            if (BEATS - q.size() == stop_at) break;
            chk("s_rval",  512'(req_valid), 512'(1));
            chk("s_stall", 512'(stall),     512'(1));
            chk("s_rdy",   512'(sched_rdy), '0);
            chk("s_data",  512'(rd_data),   512'(q[0]));
            chk("s_last",  512'(rd_last),   512'(q.size() == 1));
            chk("s_id",    512'(req_id),    512'(cmd[CORE_W +: ID_W]));
            chk("s_core",  512'(core_num),  512'(cmd[CORE_W-1:0]));
            case (mode)
                0:       ir = 1'b1;
                1:       ir = (cyc % 2 == 0);
                default: ir = 1'($urandom_range(0, 1));
            endcase
            i_ic_rdy = ir;
            tick();
            if (ir) void'(q.pop_front());
            cyc++;
        end
        i_ic_rdy = 1'b0; i_rvalid = 1'b0;
        if (stop_at >= BEATS) begin
            chk("r_drained", 512'(q.size()), '0);
            chk_idle("r_done");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CMD_W-1:0] c, hc;
        logic [B-1:0]     w;
        logic [F-1:0]     hb;

        rst_n = 1'b0; i_valid = 1'b0; i_req = '0; i_wd = '0; i_last = 1'b0;
        i_be_rdy = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_ic_rdy = 1'b0;
        #22;
        chk_zero("rst");
        rst_n = 1'b1;
        #1;
        chk("rel_rdy_low", 512'(sched_rdy), '0);
        tick();
        chk("rel_rdy_high", 512'(sched_rdy), 512'(1));

        // Stray return data while idle must be ignored
        i_rvalid = 1'b1; i_rdata = {4{rnd_beat()}};
        tick();
        i_rvalid = 1'b0;
        chk_idle("stray_rdata");
        chk("stray_rrdy", 512'(recv_rdy), '0);

        c = mk_cmd(1'b1, 16'h12, COL_W'($urandom), 3'd2, ID_W'($urandom), CORE_W'($urandom));
        do_write(c, 3, 3, 4'hA);
        do_write(rnd_cmd(1'b1), 1, 0, 4'h0);
        do_write(rnd_cmd(1'b1), BEATS, 1, 4'h5);
        do_write(rnd_cmd(1'b1), 0, 0, 4'h7);

        c = mk_cmd(1'b0, ROW_W'($urandom), COL_W'($urandom), BANK_W'($urandom), 4'd5, 2'd3);
        w = {{32{4'h4}}, {32{4'h3}}, {32{4'h2}}, {32{4'h1}}};
        do_read(c, w, 2, 0, BEATS, 1'b0, '0, '0);
        do_read(rnd_cmd(1'b0), {4{rnd_beat()}}, 1, 1, BEATS, 1'b0, '0, '0);

        // Request held during WAIT_R/SEND_R is only taken once back in IDLE
        hc = rnd_cmd(1'b1);
        hb = rnd_beat();
        do_read(rnd_cmd(1'b0), {4{rnd_beat()}}, 2, 2, BEATS, 1'b1, hc, hb);
        tick();
        i_valid = 1'b0; i_last = 1'b0;
        chk("held_cval", 512'(cmd_valid), 512'(1));
        chk("held_cmd",  512'(cmd_out),   512'(hc));
        chk("held_wdat", wdata_out,       {384'b0, hb});
        i_be_rdy = 1'b1;
        tick();
        i_be_rdy = 1'b0;
        chk_idle("held_done");

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(rnd_cmd(1'b1), int'($urandom_range(0, BEATS)), int'($urandom_range(0, 3)),
                         4'($urandom_range(1, 15)));
            else
                do_read(rnd_cmd(1'b0), {rnd_beat(), rnd_beat(), rnd_beat(), rnd_beat()},
                        int'($urandom_range(0, 3)), 2, BEATS, 1'b0, '0, '0);
        end

        w = {rnd_beat(), rnd_beat(), rnd_beat(), rnd_beat()};
        do_read(rnd_cmd(1'b0), w, 1, 0, 2, 1'b0, '0, '0);
        chk("pre_rst_beat2", 512'(rd_data), 512'(w[2*F +: F]));
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        #2;
        rst_n = 1'b1;
        chk("mid_rel_rdy_low", 512'(sched_rdy), '0);
        tick();
        chk("mid_rel_rdy_high", 512'(sched_rdy), 512'(1));
        do_read(rnd_cmd(1'b0), {4{rnd_beat()}}, 0, 1, BEATS, 1'b0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
